jt49_dcrm_sched: RTL and testbench



---
 rtl/jt49_dcrm_sched_if.sv | 24 ++
 rtl/jt49_dcrm_sched.sv | 151 +++++++++++++++
 tb/tb_jt49_dcrm_sched.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/jt49_dcrm_sched_if.sv
// Sample-set handshake between the channel mixers and the DC-removal engine.
// The master drives the strobe and channel samples, the slave returns the outputs and status.
interface jt49_dcrm_sched_if;
  logic       cen;
  logic [7:0] din_a;
  logic [7:0] din_b;
  logic [7:0] din_c;
  logic [7:0] dout_a;
  logic [7:0] dout_b;
  logic [7:0] dout_c;
  logic       done;
  logic       busy;
  logic       ovf;

  modport master (
    output cen, din_a, din_b, din_c,
    input  dout_a, dout_b, dout_c, done, busy, ovf
  );

  modport slave (
    input  cen, din_a, din_b, din_c,
    output dout_a, dout_b, dout_c, done, busy, ovf
  );
endinterface

// File: rtl/jt49_dcrm_sched.sv
// Time-multiplexed DC-removal for PSG channels A/B/C: one shared integrator and
// error-feedback datapath visits each channel in turn, outputs appear together.
module jt49_dcrm_sched #(
  parameter int DW = 10
) (
  input  logic               clk,
  input  logic               rst,
  jt49_dcrm_sched_if.slave   bus
);
  localparam int W = DW + 9;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [7:0]          smp_q [3];
  logic [7:0]          smp_d [3];
  logic signed [W-1:0] integ_q [3];
  logic signed [W-1:0] integ_d [3];
  logic signed [W-1:0] err_q [3];
  logic signed [W-1:0] err_d [3];
  logic [7:0]          stage_a_q, stage_a_d;
  logic [7:0]          stage_b_q, stage_b_d;
  logic [7:0]          dout_a_q, dout_a_d;
  logic [7:0]          dout_b_q, dout_b_d;
  logic [7:0]          dout_c_q, dout_c_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                ovf_q, ovf_d;

  logic [7:0]          x_sel;
  logic signed [W-1:0] integ_sel;
  logic signed [W-1:0] err_sel;
  logic signed [W-1:0] exact;
  logic signed [8:0]   q;
  logic signed [8:0]   pre;
  logic signed [W-1:0] integ_nx;
  logic signed [W-1:0] err_nx;

  // Shared datapath: the channel picked by idx_q is the only one evaluated this cycle.
  always_comb begin
    x_sel     = smp_q[0];
    integ_sel = integ_q[0];
    err_sel   = err_q[0];
    for (int i = 1; i < 3; i++) begin
      if (idx_q == 2'(i)) begin
        x_sel     = smp_q[i];
        integ_sel = integ_q[i];
        err_sel   = err_q[i];
      end
    end
    exact    = integ_sel + err_sel;
    q        = exact[W-1:DW];
    pre      = $signed({1'b0, x_sel}) - q;
    integ_nx = integ_sel + {{(W-9){pre[8]}}, pre};
    err_nx   = exact - {q, {DW{1'b0}}};
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    smp_d     = smp_q;
    integ_d   = integ_q;
    err_d     = err_q;
    stage_a_d = stage_a_q;
    stage_b_d = stage_b_q;
    dout_a_d  = dout_a_q;
    dout_b_d  = dout_b_q;
    dout_c_d  = dout_c_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.cen) begin
          state_d  = RUN;
          busy_d   = 1'b1;
          idx_d    = 2'd0;
          smp_d[0] = bus.din_a;
          smp_d[1] = bus.din_b;
          smp_d[2] = bus.din_c;
        end
      end
      RUN: begin
        // No pre-queuing: any strobe seen while running is lost and flagged.
        if (bus.cen) ovf_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
          if (idx_q == 2'(i)) begin
            integ_d[i] = integ_nx;
            err_d[i]   = err_nx;
          end
        end
        if (idx_q == 2'd2) begin
          dout_a_d = stage_a_q;
          dout_b_d = stage_b_q;
          dout_c_d = pre[7:0];
          done_d   = 1'b1;
          busy_d   = 1'b0;
          idx_d    = 2'd0;
          state_d  = IDLE;
        end else begin
          if (idx_q == 2'd0) stage_a_d = pre[7:0];
          else               stage_b_d = pre[7:0];
          idx_d = idx_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        smp_q[i]   <= 8'd0;
        integ_q[i] <= '0;
        err_q[i]   <= '0;
      end
      stage_a_q <= 8'd0;
      stage_b_q <= 8'd0;
      dout_a_q  <= 8'd0;
      dout_b_q  <= 8'd0;
      dout_c_q  <= 8'd0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      smp_q     <= smp_d;
      integ_q   <= integ_d;
      err_q     <= err_d;
      stage_a_q <= stage_a_d;
      stage_b_q <= stage_b_d;
      dout_a_q  <= dout_a_d;
      dout_b_q  <= dout_b_d;
      dout_c_q  <= dout_c_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.dout_a = dout_a_q;
  assign bus.dout_b = dout_b_q;
  assign bus.dout_c = dout_c_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
  assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_jt49_dcrm_sched.sv
// Directed bench for jt49_dcrm_sched: a per-channel model of the DC-removal
// equations feeds a scoreboard queue that is drained on every done pulse.
module tb_jt49_dcrm_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;

  jt49_dcrm_sched_if bus();

  jt49_dcrm_sched #(.DW(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic signed [18:0] integ_m [3];
  logic signed [18:0] err_m [3];
  logic [23:0]        exp_q [$];

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      integ_m[i] = '0;
      err_m[i]   = '0;
    end
    exp_q.delete();
  endtask

  // Reference update: exact = integ + err, q = its integer part, output = x - q.
  task automatic modelStep(input int ch, input logic [7:0] x, output logic [7:0] y);
    logic signed [18:0] exact;
    logic signed [8:0]  qm;
    logic signed [8:0]  prem;
    exact       = integ_m[ch] + err_m[ch];
    qm          = exact[18:10];
    prem        = $signed({1'b0, x}) - qm;
    integ_m[ch] = integ_m[ch] + 19'(prem);
    err_m[ch]   = exact - {qm, 10'd0};
    y           = prem[7:0];
  endtask

  // Entered just after a negedge; strobes cen for one rising edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                               input bit accept);
    logic [7:0] ya, yb, yc;
    bus.din_a = a;
    bus.din_b = b;
    bus.din_c = c;
    bus.cen   = 1'b1;
    if (accept) begin
      modelStep(0, a, ya);
      modelStep(1, b, yb);
      modelStep(2, c, yc);
      exp_q.push_back({ya, yb, yc});
    end
    @(negedge clk);
    bus.cen = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    logic [23:0] e;
    int waited;
    waited = 0;
    while (bus.done !== 1'b1 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (bus.done !== 1'b1) begin
      checkVal({tag, "_done_timeout"}, {7'd0, bus.done}, 8'd1);
    end else if (exp_q.size() == 0) begin
      checkVal({tag, "_unexpected_done"}, 8'd1, 8'd0);
    end else begin
      e = exp_q.pop_front();
      checkVal({tag, "_a"}, bus.dout_a, e[23:16]);
      checkVal({tag, "_b"}, bus.dout_b, e[15:8]);
      checkVal({tag, "_c"}, bus.dout_c, e[7:0]);
    end
  endtask

  initial begin
    logic [7:0] settled;
    bus.cen   = 1'b0;
    bus.din_a = 8'd0;
    bus.din_b = 8'd0;
    bus.din_c = 8'd0;
    modelReset();

    repeat (2) @(negedge clk);
    checkVal("rst_dout_a", bus.dout_a, 8'd0);
    checkVal("rst_dout_b", bus.dout_b, 8'd0);
    checkVal("rst_dout_c", bus.dout_c, 8'd0);
    checkVal("rst_done", {7'd0, bus.done}, 8'd0);
    checkVal("rst_busy", {7'd0, bus.busy}, 8'd0);
    checkVal("rst_ovf", {7'd0, bus.ovf}, 8'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] latency check");
    applyStimulus(8'd10, 8'd20, 8'd30, 1'b1);
    for (int j = 0; j < 3; j++) begin
      checkVal($sformatf("lat_busy_%0d", j), {7'd0, bus.busy}, 8'd1);
      checkVal($sformatf("lat_done_%0d", j), {7'd0, bus.done}, 8'd0);
      checkVal($sformatf("lat_hold_a_%0d", j), bus.dout_a, 8'd0);
      checkVal($sformatf("lat_hold_c_%0d", j), bus.dout_c, 8'd0);
      @(negedge clk);
    end
    checkVal("lat_busy_end", {7'd0, bus.busy}, 8'd0);
    checkVal("lat_done_end", {7'd0, bus.done}, 8'd1);
    checkOutput("lat");
    checkVal("lat_first_a", bus.dout_a, 8'd10);
    checkVal("lat_first_c", bus.dout_c, 8'd30);
    @(negedge clk);
    checkVal("lat_done_pulse", {7'd0, bus.done}, 8'd0);

    $display("[TB] dropped strobe check");
    applyStimulus(8'd5, 8'd6, 8'd7, 1'b1);
    @(negedge clk);
    applyStimulus(8'd200, 8'd201, 8'd202, 1'b0);
    checkOutput("drop");
    checkVal("drop_ovf", {7'd0, bus.ovf}, 8'd1);
    applyStimulus(8'd40, 8'd50, 8'd60, 1'b1);
    checkOutput("after_drop");
    checkVal("after_drop_ovf", {7'd0, bus.ovf}, 8'd1);
    checkVal("after_drop_queue", 8'(exp_q.size()), 8'd0);

    $display("[TB] reset mid-run check");
    applyStimulus(8'd99, 8'd98, 8'd97, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    for (int j = 0; j < 4; j++) begin
      checkVal($sformatf("midrst_done_%0d", j), {7'd0, bus.done}, 8'd0);
      @(negedge clk);
    end
    checkVal("midrst_a", bus.dout_a, 8'd0);
    checkVal("midrst_b", bus.dout_b, 8'd0);
    checkVal("midrst_c", bus.dout_c, 8'd0);
    checkVal("midrst_busy", {7'd0, bus.busy}, 8'd0);
    checkVal("midrst_ovf", {7'd0, bus.ovf}, 8'd0);
    applyStimulus(8'd11, 8'd22, 8'd33, 1'b1);
    checkOutput("post_rst");
    checkVal("post_rst_a", bus.dout_a, 8'd11);
    checkVal("post_rst_b", bus.dout_b, 8'd22);
    checkVal("post_rst_c", bus.dout_c, 8'd33);

    $display("[TB] convergence run, din_a = 64");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    for (int n = 1; n <= 6000; n++) begin
      applyStimulus(8'd64, 8'd0, 8'd0, 1'b1);
      checkOutput($sformatf("conv64_%0d", n));
      if (n == 1)  checkVal("conv64_first_a", bus.dout_a, 8'd64);
      if (n == 17) checkVal("conv64_17th_a", bus.dout_a, 8'd63);
    end
    settled = (bus.dout_a == 8'd0 || bus.dout_a == 8'd1 || bus.dout_a == 8'hFF) ? 8'd1 : 8'd0;
    checkVal("conv64_settled", settled, 8'd1);

    $display("[TB] convergence run, din_a = 255");
    for (int n = 1; n <= 6000; n++) begin
      applyStimulus(8'd255, 8'd0, 8'd0, 1'b1);
      checkOutput($sformatf("conv255_%0d", n));
    end

    $display("[TB] step din_a 255 -> 0");
    for (int n = 1; n <= 30; n++) begin
      applyStimulus(8'd0, 8'd0, 8'd0, 1'b1);
      checkOutput($sformatf("step_%0d", n));
      checkVal($sformatf("step_b_%0d", n), bus.dout_b, 8'd0);
      checkVal($sformatf("step_c_%0d", n), bus.dout_c, 8'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
